// File: rtl/sevseg_pkg.sv
// Shared constants, slot state type and digit-enable helper
// for the seven-segment scan multiplexer.
package sevseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] DIGIT_OFF = 4'b1111;

    typedef enum logic {
        ST_DARK,
        ST_LIT
    } slot_state_t;

    function automatic logic [3:0] onehot_low(input logic [1:0] idx);
        onehot_low = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sevseg_scan_mux_if.sv
// Value/load inputs and display-side outputs of the
// seven-segment scan multiplexer.
interface sevseg_scan_mux_if;

    logic [15:0] VALUE;
    logic        LOAD;
    logic        LZB_EN;
    logic [3:0]  D;
    logic [3:0]  DIGIT;
    logic        FRAME_DONE;

    modport master (
        output VALUE,
        output LOAD,
        output LZB_EN,
        input  D,
        input  DIGIT,
        input  FRAME_DONE
    );

    modport slave (
        input  VALUE,
        input  LOAD,
        input  LZB_EN,
        output D,
        output DIGIT,
        output FRAME_DONE
    );

endinterface

// File: rtl/sevseg_slot_timer.sv
// Slot counter, digit index and per-slot DARK/LIT phase
// for the scan multiplexer.
module sevseg_slot_timer
    import sevseg_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CW           = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       o_is_dark,
    output logic [1:0] o_dig_idx,
    output logic       o_frame_end
);

    localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
    localparam logic [1:0]    LAST_DIG = 2'(NUM_DIGITS - 1);

    logic [CW-1:0] r_slot_cnt;
    logic [1:0]    r_dig_idx;
    slot_state_t   r_state;
    slot_state_t   w_state_nxt;
    logic          w_wrap;
    logic [CW-1:0] w_slot_nxt;

    assign w_wrap     = (r_slot_cnt == LAST);
    assign w_slot_nxt = w_wrap ? '0 : r_slot_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= 2'd0;
            r_state    <= ST_DARK;
        end else begin
            r_slot_cnt <= w_slot_nxt;
            r_state    <= w_state_nxt;
            if (w_wrap) begin
                r_dig_idx <= r_dig_idx + 2'd1;
            end
        end
    end

    // Phase tracks the slot position the counter is about to enter
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_DARK: if (w_slot_nxt >= BLANK) w_state_nxt = ST_LIT;
            ST_LIT:  if (w_slot_nxt < BLANK)  w_state_nxt = ST_DARK;
            default: w_state_nxt = ST_DARK;
        endcase
    end

    assign o_is_dark   = (r_state == ST_DARK);
    assign o_dig_idx   = r_dig_idx;
    assign o_frame_end = w_wrap && (r_dig_idx == LAST_DIG);

endmodule

// File: rtl/sevseg_scan_mux.sv
// Four-digit hex scan multiplexer: double-buffered value,
// leading-zero blanking, nibble and digit-enable registers.
module sevseg_scan_mux
    import sevseg_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CW           = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    sevseg_scan_mux_if.slave  bus
);

    logic        w_is_dark;
    logic [1:0]  w_dig_idx;
    logic        w_frame_end;
    logic [3:0]  w_nib;
    logic        w_suppress;
    logic        w_lit;

    logic [15:0] r_disp;
    logic [15:0] r_pend;
    logic        r_pend_vld;
    logic        r_lit_q;
    logic [1:0]  r_idx_q;
    logic [3:0]  r_d;
    logic [3:0]  r_digit;

    sevseg_slot_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CW           (CW)
    ) u_timer (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .o_is_dark   (w_is_dark),
        .o_dig_idx   (w_dig_idx),
        .o_frame_end (w_frame_end)
    );

    // A LOAD on the boundary bypasses the pending buffer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_disp     <= 16'h0000;
            r_pend     <= 16'h0000;
            r_pend_vld <= 1'b0;
        end else begin
            if (bus.LOAD) begin
                r_pend <= bus.VALUE;
            end
            if (w_frame_end) begin
                r_pend_vld <= 1'b0;
                if (bus.LOAD) begin
                    r_disp <= bus.VALUE;
                end else if (r_pend_vld) begin
                    r_disp <= r_pend;
                end
            end else if (bus.LOAD) begin
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign w_nib = r_disp[{w_dig_idx, 2'b00} +: 4];

    always_comb begin
        w_suppress = 1'b0;
        if (bus.LZB_EN) begin
            case (w_dig_idx)
                2'd3:    w_suppress = (r_disp[15:12] == 4'h0);
                2'd2:    w_suppress = (r_disp[15:8] == 8'h00);
                2'd1:    w_suppress = (r_disp[15:4] == 12'h000);
                default: w_suppress = 1'b0;
            endcase
        end
    end

    assign w_lit = !w_is_dark && !w_suppress;

    // DIGIT trails D by one cycle to match the decoder's SEG register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_d     <= 4'h0;
            r_lit_q <= 1'b0;
            r_idx_q <= 2'd0;
            r_digit <= DIGIT_OFF;
        end else begin
            r_d     <= w_nib;
            r_lit_q <= w_lit;
            r_idx_q <= w_dig_idx;
            r_digit <= r_lit_q ? onehot_low(r_idx_q) : DIGIT_OFF;
        end
    end

    assign bus.D          = r_d;
    assign bus.DIGIT      = r_digit;
    assign bus.FRAME_DONE = w_frame_end;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// Self-checking bench for sevseg_scan_mux against a cycle-indexed
// model of the displayed value and scan timing.
module tb_sevseg_scan_mux;

    localparam int TD = 8;
    localparam int BL = 2;
    localparam int FR = TD * 4;
    localparam int HN = 1024;

    logic clk;
    logic rst_n;

    sevseg_scan_mux_if bus ();

    sevseg_scan_mux #(
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BL),
        .CW           (3)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int j       = 0;

    logic [15:0] disp_h [0:HN-1];
    logic        lzb_h  [0:HN-1];
    logic [15:0] pend;
    logic        pvld;

    function automatic int slot_of(input int c);
        return c % TD;
    endfunction

    function automatic int dig_of(input int c);
        return (c / TD) % 4;
    endfunction

    function automatic logic lit_of(input int c);
        int d;
        logic [15:0] hi;
        d = dig_of(c);
        hi = disp_h[c] >> (4 * d);
        if (slot_of(c) < BL) return 1'b0;
        if (lzb_h[c] && d != 0 && hi == 16'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_cycle();
        logic [3:0]  ed;
        logic [3:0]  eg;
        logic        ef;
        logic [15:0] t;
        logic [3:0]  one;
        one = 4'b0001;
        ed = 4'h0;
        eg = 4'b1111;
        if (j >= 1) begin
            t  = disp_h[j-1] >> (4 * dig_of(j-1));
            ed = t[3:0];
        end
        if (j >= 2 && lit_of(j-2)) begin
            eg = ~(one << dig_of(j-2));
        end
        ef = ((j % FR) == FR - 1);
        n_tests++;
        assert (bus.D === ed) else begin
            n_fail++;
            $error("FAIL D cyc=%0d got=%h exp=%h", j, bus.D, ed);
        end
        n_tests++;
        assert (bus.DIGIT === eg) else begin
            n_fail++;
            $error("FAIL DIGIT cyc=%0d got=%b exp=%b", j, bus.DIGIT, eg);
        end
        n_tests++;
        assert (bus.FRAME_DONE === ef) else begin
            n_fail++;
            $error("FAIL FRAME_DONE cyc=%0d got=%b exp=%b",
                   j, bus.FRAME_DONE, ef);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] v,
                        input logic lz);
        check_cycle();
        bus.LOAD   = ld;
        bus.VALUE  = v;
        bus.LZB_EN = lz;
        lzb_h[j] = lz;
        if ((j % FR) == FR - 1) begin
            disp_h[j+1] = ld ? v : (pvld ? pend : disp_h[j]);
            pvld = 1'b0;
            if (ld) pend = v;
        end else begin
            disp_h[j+1] = disp_h[j];
            if (ld) begin
                pend = v;
                pvld = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        j++;
    endtask

    task automatic check_reset_outs(input string tag);
        n_tests++;
        assert (bus.DIGIT === 4'b1111 && bus.D === 4'h0 &&
                bus.FRAME_DONE === 1'b0) else begin
            n_fail++;
            $error("FAIL %s got D=%h DIGIT=%b FD=%b exp D=0 DIGIT=1111 FD=0",
                   tag, bus.D, bus.DIGIT, bus.FRAME_DONE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ld;
        logic [15:0] v;
        logic        lz;

        bus.LOAD   = 1'b0;
        bus.VALUE  = 16'h0;
        bus.LZB_EN = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        #1;
        j = 0;
        disp_h[0] = 16'h0;
        pend = 16'h0;
        pvld = 1'b0;

        // Directed frames: first load, overwrite, boundary load, blanking
        for (int c = 0; c < 192; c++) begin
            ld = 1'b0;
            v  = 16'(($urandom));
            case (c)
                3:   begin ld = 1'b1; v = 16'h1234; end
                40:  begin ld = 1'b1; v = 16'hAAAA; end
                50:  begin ld = 1'b1; v = 16'hBBBB; end
                95:  begin ld = 1'b1; v = 16'h5555; end
                100: begin ld = 1'b1; v = 16'h0007; end
                150: begin ld = 1'b1; v = 16'h0000; end
                default: ;
            endcase
            lz = (c >= 100);
            step(ld, v, lz);
        end

        // Random loads, values with leading zeros, random blanking enable
        for (int c = 0; c < 400; c++) begin
            v = 16'($urandom);
            case ($urandom % 4)
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            ld = (($urandom % 5) == 0);
            lz = 1'($urandom % 2);
            step(ld, v, lz);
        end

        step(1'b1, 16'hC3E9, 1'b0);
        while ((j % FR) != 20) step(1'b0, 16'h0, 1'b0);

        // Asynchronous reset in the middle of the digit-2 slot
        check_cycle();
        #2 rst_n = 1'b0;
        #1 check_reset_outs("async_reset_now");
        @(posedge clk);
        #1 check_reset_outs("reset_held");
        #4 rst_n = 1'b1;
        #1;
        j = 0;
        disp_h[0] = 16'h0;
        pend = 16'h0;
        pvld = 1'b0;

        for (int c = 0; c < 130; c++) begin
            ld = (c == 40);
            v  = 16'h0F0F;
            step(ld, v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
